// File: rtl/blaster_pkg.sv
// Shared UART types, constants and the baud-divider helper.
package blaster_pkg;

    typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Rounded clocks per oversample tick.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        longint den;
        den = longint'(baud) * longint'(os);
        return int'((longint'(clk_hz) + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart232_rx_fifo.sv
// First-word-fall-through queue; head word is visible whenever not empty.
module uart232_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same clk frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart232_rx.sv
// 8N1 receiver for the rx232 pad: synchroniser, oversample divider,
// majority-vote sampler and framing FSM feeding a small FWFT queue.
module uart232_rx
    import blaster_pkg::*;
#(
    parameter int CLK_HZ     = 48_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx232,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    // state    | meaning
    // RX_ARM   | wait for a high line before looking for a start edge
    // RX_IDLE  | line idle, watching for a 1->0 edge
    // RX_START | checking the start bit at mid-bit
    // RX_DATA  | shifting in 8 data bits, LSB first
    // RX_STOP  | checking the stop bit, then push or flag framing error

    localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(UART_DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

    uart_rx_state_t            state;
    logic                      sync1;
    logic                      rxs;
    logic                      rxs_d;
    logic [DW-1:0]             div_cnt;
    logic [TW-1:0]             tick_cnt;
    logic [TW-1:0]             tick_next;
    logic [BW-1:0]             bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      samp0;
    logic                      samp1;
    logic                      maj;
    logic                      os_tick;
    logic                      samp_last;
    logic                      bit_end;
    logic                      start_edge;
    logic                      push;
    logic                      fifo_full;
    logic                      fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rx232;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    assign start_edge = rxs_d & ~rxs;
    assign os_tick    = (div_cnt == '0);

    // Reloading on the start edge puts mid-bit samples a fixed distance from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if ((state == RX_IDLE) && start_edge) begin
            div_cnt <= DIV_LAST;
        end else if (os_tick) begin
            div_cnt <= DIV_LAST;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    assign samp_last = os_tick && (tick_next == TICK_S2);
    assign bit_end   = os_tick && (tick_cnt == TICK_LAST);
    assign maj       = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    assign push      = (state == RX_STOP) && samp_last && maj;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RX_ARM;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            samp0     <= 1'b1;
            samp1     <= 1'b1;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (os_tick) begin
                tick_cnt <= tick_next;
                if (tick_next == TICK_S0) samp0 <= rxs;
                if (tick_next == TICK_S1) samp1 <= rxs;
            end
            case (state)
                RX_ARM: begin
                    if (rxs) state <= RX_IDLE;
                end
                RX_IDLE: begin
                    if (start_edge) begin
                        state    <= RX_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (samp_last && maj) begin
                        state   <= RX_IDLE;
                        rx_busy <= 1'b0;
                    end else if (bit_end) begin
                        state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (samp_last) shreg <= {maj, shreg[UART_DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) state <= RX_STOP;
                        else                     bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (samp_last) begin
                        rx_busy <= 1'b0;
                        if (maj) begin
                            state <= RX_IDLE;
                        end else begin
                            state     <= RX_ARM;
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= RX_ARM;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) overrun <= 1'b0;
        else       overrun <= push & fifo_full & ~(rx_ready & ~fifo_empty);
    end

    uart232_rx_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rx_ready),
        .rd_data   (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart232_rx.sv
// Scoreboard bench for uart232_rx: expected bytes queued at send, received bytes queued by a monitor.
`timescale 1ns/1ps
module tb_uart232_rx;
    localparam int  CLK_HZ = 48_000_000;
    localparam int  BAUD   = 1_000_000;
    localparam real BIT_NS = 1.0e9 / BAUD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx232 = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, rx_busy;

    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    realtime    got_t[$];
    realtime    start_t;
    int frame_cnt = 0, ovr_cnt = 0, both_cnt = 0, valid_clks = 0, stable_viol = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart232_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rx232(rx232), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
    );

    always #10.417 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (!rx_valid || rx_data !== prev_data)) stable_viol++;
            if (rx_valid && rx_ready) begin
                got_q.push_back(rx_data);
                got_t.push_back($realtime);
            end
            if (rx_valid)             valid_clks++;
            if (frame_err)            frame_cnt++;
            if (overrun)              ovr_cnt++;
            if (frame_err && overrun) both_cnt++;
            prev_hold = rx_valid && !rx_ready;
            prev_data = rx_data;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input real bit_ns, input logic stop_v);
        rx232 = 1'b0;
        start_t = $realtime;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx232 = d[i];
            #(bit_ns);
        end
        rx232 = stop_v;
        #(bit_ns);
    endtask

    task automatic wait_got(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #3;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rx232 = 1'b1; rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun, rx_busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=000", {rx_valid, rx_data, frame_err, overrun, rx_busy});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({rx_valid, rx_busy} !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=00", {rx_valid, rx_busy});
        end
    endtask

    task automatic test_single();
        int f0, o0, v0; bit ok; logic [7:0] e, g; realtime t;
        rx_ready = 1'b1; f0 = frame_cnt; o0 = ovr_cnt; v0 = valid_clks;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, BIT_NS, 1'b1);
        wait_got(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout got=0 bytes exp=1"); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL single_data got=%h exp=%h", g, e); end
            checks++;
            if (t - start_t >= 10.0 * BIT_NS) begin
                failures++; $display("FAIL single_latency got=%0t exp<%0t", t - start_t, 10.0 * BIT_NS);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (valid_clks - v0 != 1) begin failures++; $display("FAIL single_valid_width got=%0d exp=1", valid_clks - v0); end
        checks++;
        if (frame_cnt != f0 || ovr_cnt != o0) begin
            failures++; $display("FAIL single_err_pulses got=%0d/%0d exp=0/0", frame_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_glitch();
        int f0, v0; bit ok; logic [7:0] e, g;
        rx_ready = 1'b1; f0 = frame_cnt; v0 = valid_clks;
        @(negedge clk); rx232 = 1'b0;
        repeat (3) @(negedge clk);
        rx232 = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_start_seen got=%b exp=1", rx_busy); end
        repeat (100) @(negedge clk);
        checks++;
        if (valid_clks != v0 || frame_cnt != f0 || got_q.size() != 0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject got=valid%0d ferr%0d busy%b exp=0 0 0", valid_clks - v0, frame_cnt - f0, rx_busy);
        end
        exp_q.push_back(8'h00);
        send_byte(8'h00, BIT_NS, 1'b1);
        wait_got(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL glitch_next_timeout got=0 bytes exp=1"); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front(); void'(got_t.pop_front());
            checks++;
            if (g !== e) begin failures++; $display("FAIL glitch_next_data got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_frame_err();
        int f0; bit ok; logic [7:0] e, g;
        rx_ready = 1'b1; f0 = frame_cnt;
        send_byte(8'h55, BIT_NS, 1'b0);
        #(BIT_NS);
        @(negedge clk);
        checks++;
        if (frame_cnt != f0 + 1) begin failures++; $display("FAIL frame_err_pulses got=%0d exp=1", frame_cnt - f0); end
        checks++;
        if (got_q.size() != 0 || rx_valid !== 1'b0) begin
            failures++; $display("FAIL frame_fifo_empty got=%0d bytes valid=%b exp=0", got_q.size(), rx_valid);
        end
        checks++;
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL frame_busy got=%b exp=0", rx_busy); end
        rx232 = 1'b1;
        #(BIT_NS);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, BIT_NS, 1'b1);
        wait_got(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL frame_next_timeout got=0 bytes exp=1"); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front(); void'(got_t.pop_front());
            checks++;
            if (g !== e) begin failures++; $display("FAIL frame_next_data got=%h exp=%h", g, e); end
        end
        checks++;
        if (frame_cnt != f0 + 1) begin failures++; $display("FAIL frame_err_after got=%0d exp=1", frame_cnt - f0); end
    endtask

    task automatic test_overrun();
        int o0; bit ok; logic [7:0] e, g;
        rx_ready = 1'b0; o0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_byte(8'(i), BIT_NS, 1'b1);
            if (i == 4) begin
                checks++;
                if (ovr_cnt != o0) begin failures++; $display("FAIL overrun_early got=%0d exp=0", ovr_cnt - o0); end
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (ovr_cnt != o0 + 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt - o0); end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
            failures++; $display("FAIL overrun_head got=%b/%h exp=1/01", rx_valid, rx_data);
        end
        @(negedge clk); rx_ready = 1'b1;
        wait_got(4, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL overrun_drain_timeout got=%0d bytes exp=4", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); void'(got_t.pop_front());
            checks++;
            if (g !== e) begin failures++; $display("FAIL overrun_drain_data got=%h exp=%h", g, e); end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0 || got_q.size() != 0 || exp_q.size() != 0) begin
            failures++; $display("FAIL overrun_drain_end got=valid%b extra%0d missing%0d exp=0 0 0", rx_valid, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_full_push_pop();
        int o0; bit ok; bit hit; logic [7:0] e, g;
        rx_ready = 1'b0; o0 = ovr_cnt; hit = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i * 8'h11));
            send_byte(8'(i * 8'h11), BIT_NS, 1'b1);
        end
        exp_q.push_back(8'h55);
        fork
            send_byte(8'h55, BIT_NS, 1'b1);
            begin
                for (int i = 0; i < 5000 && !hit; i++) begin
                    @(negedge clk);
                    if (dut.push === 1'b1) begin
                        hit = 1'b1;
                        rx_ready = 1'b1;
                    end
                end
            end
        join
        checks++;
        if (!hit) begin failures++; $display("FAIL fullpp_push_seen got=0 exp=1"); end
        wait_got(5, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL fullpp_timeout got=%0d bytes exp=5", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); void'(got_t.pop_front());
            checks++;
            if (g !== e) begin failures++; $display("FAIL fullpp_data got=%h exp=%h", g, e); end
        end
        checks++;
        if (ovr_cnt != o0) begin failures++; $display("FAIL fullpp_overrun got=%0d exp=0", ovr_cnt - o0); end
    endtask

    task automatic test_reset_mid();
        int f0, o0, v0; bit ok; logic [7:0] e, g;
        rx_ready = 1'b1; f0 = frame_cnt; o0 = ovr_cnt; v0 = valid_clks;
        fork
            send_byte(8'hFF, BIT_NS, 1'b1);
            begin
                #(BIT_NS * 5.3);
                @(negedge clk); reset = 1'b1;
                @(negedge clk); reset = 1'b0;
                checks++;
                if ({rx_valid, rx_busy} !== 2'b00) begin
                    failures++; $display("FAIL midreset_state got=%b exp=00", {rx_valid, rx_busy});
                end
            end
        join
        #(BIT_NS);
        exp_q.push_back(8'h81);
        send_byte(8'h81, BIT_NS, 1'b1);
        wait_got(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midreset_timeout got=0 bytes exp=1"); end
        else begin
            e = exp_q.pop_front(); g = got_q.pop_front(); void'(got_t.pop_front());
            checks++;
            if (g !== e) begin failures++; $display("FAIL midreset_data got=%h exp=%h", g, e); end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (valid_clks - v0 != 1 || frame_cnt != f0 || ovr_cnt != o0) begin
            failures++;
            $display("FAIL midreset_extra got=valid%0d ferr%0d ovr%0d exp=1 0 0", valid_clks - v0, frame_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int f0, o0, s0; bit ok; bit done; logic [7:0] lfsr, e, g;
        f0 = frame_cnt; o0 = ovr_cnt; s0 = stable_viol; done = 1'b0; lfsr = 8'hA1;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    exp_q.push_back(lfsr);
                    send_byte(lfsr, (i < 50) ? BIT_NS / 1.02 : BIT_NS / 0.98, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    rx_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk); rx_ready = 1'b1;
            end
        join
        wait_got(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d bytes exp=100", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); void'(got_t.pop_front());
            checks++;
            if (g !== e) begin failures++; $display("FAIL b2b_data got=%h exp=%h", g, e); end
        end
        checks++;
        if (frame_cnt != f0 || ovr_cnt != o0) begin
            failures++; $display("FAIL b2b_errors got=ferr%0d ovr%0d exp=0 0", frame_cnt - f0, ovr_cnt - o0);
        end
        checks++;
        if (stable_viol != s0) begin failures++; $display("FAIL b2b_head_stable got=%0d exp=0", stable_viol - s0); end
        checks++;
        if (both_cnt != 0) begin failures++; $display("FAIL err_same_clk got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
